div_clk_monitor: RTL
====================

DIV_CLK_MONITOR -- requirements
Module: div_clk_monitor

Interface
REQ-001 Parameter EXP_PERIOD, default 5: expected divided-clock period in clk cycles; legal range 2..254.
REQ-002 Parameter EXP_HIGH, default 2: expected high time in clk cycles; legal range 1..EXP_PERIOD-1.
REQ-003 Parameter LOCK_COUNT, default 4: consecutive matching periods required to lock; legal range 1..15.
REQ-004 clk  input  1  system clock; all state is updated on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 div_in  input  1  divided clock from the divide-by-N stage; asynchronous to clk, so treat it as an asynchronous input.
REQ-007 clear  input  1  synchronous restart: returns the FSM to IDLE and clears counters and flags.
REQ-008 rise_tick  output  1  one-cycle pulse on each synchronized rising edge of div_in.
REQ-009 fall_tick  output  1  one-cycle pulse on each synchronized falling edge of div_in.
REQ-010 locked  output  1  high while the FSM is in LOCKED.
REQ-011 fault  output  1  sticky error flag; high while the FSM is in FAULT.
REQ-012 period_cnt  output  8  last completed period, measured rising edge to rising edge.
REQ-013 high_cnt  output  8  last completed high time, measured rising edge to falling edge.

Function
REQ-014 div_in SHALL pass through a 2-flop synchronizer, followed by one history flop for edge detection.
REQ-015 rise_tick and fall_tick SHALL be registered outputs, asserted exactly 3 clk cycles after the first clk edge that samples the new div_in level.
REQ-016 A running counter SHALL restart at 1 on each rise_tick, increment every cycle, and saturate at 255.
REQ-017 On rise_tick the counter value SHALL be loaded into period_cnt; on fall_tick it SHALL be loaded into high_cnt.
REQ-018 FSM states: IDLE, MEASURE, LOCKED, FAULT; encoding is a 2-bit enum.
REQ-019 IDLE -> MEASURE on the first rise_tick; no period is evaluated at that edge.
REQ-020 MEASURE: each rise_tick evaluates the period just completed.
  - Period == EXP_PERIOD: match count increments.
  - Period differs: match count returns to 0.
  - Match count reaches LOCK_COUNT: go to LOCKED.
REQ-021 LOCKED: a rise_tick with period != EXP_PERIOD SHALL cause a transition to FAULT.
REQ-022 LOCKED: a counter reaching 255 (edge timeout / stopped clock) SHALL cause a transition to FAULT.
REQ-023 MEASURE: a counter reaching 255 SHALL cause a transition to IDLE, not FAULT.
REQ-024 FAULT SHALL be exited only by clear or reset.
REQ-025 clear SHALL have priority over all edge events in the same cycle; on that cycle's edge the FSM enters IDLE and ticks are suppressed.
REQ-026 Synchronizer flops SHALL be unaffected by clear, to avoid false edges.
REQ-027 locked and fault SHALL be registered outputs, changing on the cycle after the evaluating rise_tick.

Reset
REQ-028 rst_n low SHALL asynchronously force:
  - FSM = IDLE.
  - All counters, period_cnt and high_cnt = 0.
  - Synchronizer and history flops = 0.
  - All outputs = 0.
REQ-029 Reset asserted mid-period SHALL discard the partial measurement; after release, the first rising edge is treated as in IDLE.

Configuration
REQ-030 Macro DIVMON_DUTY_CHECK_EN.
  - Defined: on each fall_tick in MEASURE or LOCKED, the high time SHALL be compared with EXP_HIGH.
  - A mismatch in LOCKED SHALL force FAULT; a mismatch in MEASURE SHALL zero the match count.
  - Undefined: high_cnt is still reported, but duty is never checked.

Structure
REQ-031 Package div_pkg SHALL hold the FSM state enum, the counter width constant (8), and the saturation value (255).
REQ-032 The synchronizer plus edge detector SHALL be a sub-module named div_edge_sync (ports clk, rst_n, async_in, rise, fall); the FSM and counters stay in the top level.

Verification
REQ-033 Feed div_in from a divide-by-5 source, high 2 / low 3 -> locked rises after the 5th rise_tick; period_cnt=5, high_cnt=2, fault=0.
REQ-034 Once locked, stretch one period to 6 -> fault=1 and locked=0 the cycle after that rise_tick; fault stays 1 for 20 further periods.
REQ-035 Once locked, hold div_in at 0 -> fault=1 when the counter reaches 255; period_cnt unchanged.
REQ-036 With DIVMON_DUTY_CHECK_EN defined and locked, change the duty to high 3 / low 2 (period 5) -> fault=1 at fall_tick. Same stimulus with the macro undefined -> locked stays 1 and high_cnt=3.
REQ-037 Assert clear in the same cycle as a rise_tick while in FAULT -> next cycle FSM=IDLE, fault=0, no tick output; the lock sequence restarts.
REQ-038 Assert rst_n low for 1 cycle mid-MEASURE (match count 2) -> all outputs 0 immediately; relock requires 5 rising edges.

Source files
------------

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and constants for the divided-clock monitor
package div_pkg;

    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_SAT = 8'd255;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_FAULT   = 2'd3
    } mon_state_t;

    // Saturating increment: the edge counter parks at CNT_SAT so a stopped clock is visible
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_SAT) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/div_edge_sync.sv
// rtl/div_edge_sync.sv - two-flop synchronizer plus registered edge detector
module div_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise,
    output logic fall
);

    logic sync1;
    logic sync2;
    logic hist;

    // Synchronize the divided clock, keep one level of history and register the edge pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            hist  <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync1 <= async_in;
            sync2 <= sync1;
            hist  <= sync2;
            rise  <= sync2 & ~hist;
            fall  <= ~sync2 & hist;
        end
    end

endmodule

// File: rtl/div_clk_monitor.sv
// rtl/div_clk_monitor.sv - divided-clock period/duty monitor with lock FSM; duty check under DIVMON_DUTY_CHECK_EN
module div_clk_monitor
    import div_pkg::*;
#(
    parameter int EXP_PERIOD = 5,
    parameter int EXP_HIGH   = 2,
    parameter int LOCK_COUNT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             div_in,
    input  logic             clear,
    output logic             rise_tick,
    output logic             fall_tick,
    output logic             locked,
    output logic             fault,
    output logic [CNT_W-1:0] period_cnt,
    output logic [CNT_W-1:0] high_cnt
);

    localparam logic [CNT_W-1:0] EXP_P  = CNT_W'(EXP_PERIOD);
    localparam logic [CNT_W-1:0] EXP_H  = CNT_W'(EXP_HIGH);
    localparam logic [3:0]       LOCK_M = 4'(LOCK_COUNT);

`ifdef DIVMON_DUTY_CHECK_EN
    localparam logic DUTY_CHK = 1'b1;
`else
    localparam logic DUTY_CHK = 1'b0;
`endif

    logic             rise;
    logic             fall;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       match_cnt;
    logic [3:0]       match_inc;
    logic             period_ok;
    logic             duty_bad;
    logic             timeout;
    mon_state_t       state;

    div_edge_sync u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (div_in),
        .rise     (rise),
        .fall     (fall)
    );

    // At a tick edge cnt still holds the length of the interval that just ended
    assign period_ok = (cnt == EXP_P);
    assign duty_bad  = DUTY_CHK & (cnt != EXP_H);
    assign timeout   = (cnt == CNT_SAT);
    assign match_inc = match_cnt + 4'd1;

    // Output tick pulses; clear masks any edge arriving in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_tick <= 1'b0;
            fall_tick <= 1'b0;
        end else begin
            rise_tick <= rise & ~clear;
            fall_tick <= fall & ~clear;
        end
    end

    // Running interval counter and the captured period / high-time measurements
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            period_cnt <= '0;
            high_cnt   <= '0;
        end else if (clear) begin
            cnt        <= '0;
            period_cnt <= '0;
            high_cnt   <= '0;
        end else begin
            if (rise_tick) begin
                period_cnt <= cnt;
                cnt        <= 8'd1;
            end else begin
                cnt <= sat_inc(cnt);
            end
            if (fall_tick) begin
                high_cnt <= cnt;
            end
        end
    end

    // Lock FSM with registered locked/fault flags; clear beats every edge event
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            match_cnt <= '0;
            locked    <= 1'b0;
            fault     <= 1'b0;
        end else if (clear) begin
            state     <= ST_IDLE;
            match_cnt <= '0;
            locked    <= 1'b0;
            fault     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // First edge only starts the measurement; no complete period exists yet
                    if (rise_tick) begin
                        state     <= ST_MEASURE;
                        match_cnt <= '0;
                    end
                end
                ST_MEASURE: begin
                    if (rise_tick) begin
                        if (period_ok) begin
                            if (match_inc >= LOCK_M) begin
                                state     <= ST_LOCKED;
                                match_cnt <= '0;
                                locked    <= 1'b1;
                            end else begin
                                match_cnt <= match_inc;
                            end
                        end else begin
                            match_cnt <= '0;
                        end
                    end else if (fall_tick && duty_bad) begin
                        match_cnt <= '0;
                    end else if (timeout) begin
                        // Source stopped before lock: start over rather than flag an error
                        state     <= ST_IDLE;
                        match_cnt <= '0;
                    end
                end
                ST_LOCKED: begin
                    if ((rise_tick && !period_ok) ||
                        (fall_tick && duty_bad) ||
                        (!rise_tick && timeout)) begin
                        state  <= ST_FAULT;
                        locked <= 1'b0;
                        fault  <= 1'b1;
                    end
                end
                ST_FAULT: begin
                    // Sticky until clear or reset
                    fault <= 1'b1;
                end
                default: begin
                    state     <= ST_IDLE;
                    match_cnt <= '0;
                    locked    <= 1'b0;
                    fault     <= 1'b0;
                end
            endcase
        end
    end

endmodule
